// File: rtl/fifo_ctrl_pkg.sv
//==============================================================================
// Module   : fifo_ctrl_pkg
// Brief    : Shared types and constants for the FIFO write-port arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package fifo_ctrl_pkg;

  // Arbiter FSM states; LOCK is only reachable when burst hold is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2,
    LOCK  = 2'd3
  } arb_state_t;

  localparam int FIFO_DATA_W = 16;
  localparam int FIFO_DEPTH  = 16;

  // Bits needed to hold a credit count from 0 up to and including depth.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. The search starts one past
//            rr_ptr and wraps; gnt is one-hot and forced to zero when enable
//            is low. winner holds the search result even when not enabled.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   winner
);

  // Walk the requesters starting after the last winner; the first hit wins.
  always_comb begin
    int   w_idx;
    logic w_found;
    gnt     = '0;
    winner  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        winner  = IDX_W'(w_idx);
      end
    end
    if (w_found && enable) begin
      gnt[winner] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
//==============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Shares one FIFO write port between NUM_REQ producers with
//            round-robin arbitration and a local credit counter tracking free
//            FIFO slots. One registered write per cycle, never into a full
//            FIFO. Optional burst hold is built when FIFO_ARB_LOCK_EN is
//            defined; otherwise req_lock is ignored.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = FIFO_DATA_W,
  parameter int DEPTH   = FIFO_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_lock,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        fifo_write,
  output logic [DATA_W-1:0]           fifo_din,
  input  logic                        fifo_rd,
  output logic [credit_w(DEPTH)-1:0]  credit_cnt,
  output logic                        err_undf
);

  localparam int                 CW        = credit_w(DEPTH);
  localparam int                 IDX_W     = $clog2(NUM_REQ);
  localparam logic [CW-1:0]      C_FULL    = CW'(DEPTH);
  localparam logic [IDX_W-1:0]   C_PTR_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     w_winner;
  logic [NUM_REQ-1:0]   w_arb_req;
  logic [NUM_REQ-1:0]   w_arb_gnt;
  logic [DATA_W-1:0]    w_win_data;
  logic [CW-1:0]        w_credit_nxt;
  logic                 w_any_req;
  logic                 w_can_accept;
  logic                 w_accept;
  logic                 w_rd_ok;
  logic                 w_hold;
  logic                 w_lock_win;

`ifdef FIFO_ARB_LOCK_EN
  logic [IDX_W-1:0]     r_lock_owner;

  // While the owner keeps req and req_lock high, it is the only candidate.
  assign w_hold     = (r_state == LOCK) && req[r_lock_owner] && req_lock[r_lock_owner];
  assign w_arb_req  = w_hold ? (NUM_REQ'(1) << r_lock_owner) : req;
  assign w_lock_win = req_lock[w_winner];

  // Capture the burst owner whenever a locking requester is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock_owner <= '0;
    end else if (w_accept && w_lock_win) begin
      r_lock_owner <= w_winner;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^req_lock;
  assign w_hold        = 1'b0;
  assign w_arb_req     = req;
  assign w_lock_win    = 1'b0;
`endif

  // A word may be taken when a slot is free, or one is freed this very cycle.
  // Nothing is taken while reset is high, since that write would be dropped.
  assign w_any_req    = |w_arb_req;
  assign w_can_accept = ((credit_cnt != '0) || fifo_rd) && !reset;
  assign w_rd_ok      = fifo_rd && (credit_cnt != C_FULL);
  assign w_credit_nxt = credit_cnt - CW'(w_accept) + CW'(w_rd_ok);
  assign w_win_data   = req_data[w_winner*DATA_W +: DATA_W];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (w_arb_req),
    .rr_ptr  (r_rr_ptr),
    .enable  (w_can_accept),
    .gnt     (w_arb_gnt),
    .winner  (w_winner)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: tracks whether the port is idle, flowing, starved or held.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = !w_accept ? STALL : (w_lock_win ? LOCK : GRANT);
        end
      end
      STALL: begin
        if (fifo_rd) begin
          w_state_nxt = !w_any_req ? IDLE : (w_lock_win ? LOCK : GRANT);
        end
      end
      default: begin
        // GRANT, and LOCK once its owner has let go.
        if (w_hold) begin
          w_state_nxt = LOCK;
        end else if (!w_any_req) begin
          w_state_nxt = IDLE;
        end else if (w_accept && w_lock_win) begin
          w_state_nxt = LOCK;
        end else if ((w_credit_nxt == '0) && !fifo_rd) begin
          w_state_nxt = STALL;
        end else begin
          w_state_nxt = GRANT;
        end
      end
    endcase
  end

  // FSM outputs: the grant is the arbiter pick, already qualified by credit.
  always_comb begin
    gnt      = w_arb_gnt;
    w_accept = |w_arb_gnt;
  end

  // Write register, round-robin pointer, credit counter and underflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_write <= 1'b0;
      fifo_din   <= '0;
      r_rr_ptr   <= C_PTR_RST;
      credit_cnt <= C_FULL;
      err_undf   <= 1'b0;
    end else begin
      fifo_write <= w_accept;
      credit_cnt <= w_credit_nxt;
      if (w_accept) begin
        fifo_din <= w_win_data;
        r_rr_ptr <= w_winner;
      end
      if (fifo_rd && (credit_cnt == C_FULL)) begin
        err_undf <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
//==============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed and randomised bench for fifo_wr_arbiter with a
//            transaction-level reference model (pointer, credit count, sticky
//            error, pending write). Honours FIFO_ARB_LOCK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;
  import fifo_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int DP = 16;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_lock;
  logic [NR-1:0]     gnt;
  logic              fifo_write;
  logic [DW-1:0]     fifo_din;
  logic              fifo_rd;
  logic [4:0]        credit_cnt;
  logic              err_undf;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(DP)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_lock   (req_lock),
    .gnt        (gnt),
    .fifo_write (fifo_write),
    .fifo_din   (fifo_din),
    .fifo_rd    (fifo_rd),
    .credit_cnt (credit_cnt),
    .err_undf   (err_undf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_fail   = 0;

  // Reference model state
  bit            m_valid  = 1'b0;
  int            m_ptr;
  int            m_credit;
  bit            m_err;
  bit            m_write;
  logic [DW-1:0] m_din;
  int            m_owner;
  logic [NR-1:0] obs_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs at the falling edge against
  // the model, advance the model, then return just after the rising edge.
  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] lk,
                      input logic rd, input logic rs);
    int            win;
    bit            hold;
    bit            acc;
    logic [NR-1:0] eg;
    req      = r;
    req_lock = lk;
    fifo_rd  = rd;
    reset    = rs;
    @(negedge clock);
    if (m_valid) begin
      chk("fifo_write", {31'd0, fifo_write}, {31'd0, m_write});
      if (m_write) chk("fifo_din", {16'd0, fifo_din}, {16'd0, m_din});
      chk("credit_cnt", {27'd0, credit_cnt}, m_credit);
      chk("err_undf", {31'd0, err_undf}, {31'd0, m_err});
    end
    win  = -1;
    hold = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
    if (m_owner >= 0 && r[m_owner] && lk[m_owner]) begin
      hold = 1'b1;
      win  = m_owner;
    end else begin
      m_owner = -1;
    end
`endif
    if (!hold) begin
      for (int k = 1; k <= NR; k++) begin
        if (win < 0 && r[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      end
    end
    acc = !rs && (win >= 0) && ((m_credit > 0) || rd);
    eg  = '0;
    if (acc) eg[win] = 1'b1;
    obs_gnt = gnt;
    if (m_valid || rs) chk("gnt", {28'd0, gnt}, {28'd0, eg});
    if (rs) begin
      m_valid  = 1'b1;
      m_ptr    = NR - 1;
      m_credit = DP;
      m_err    = 1'b0;
      m_write  = 1'b0;
      m_din    = '0;
      m_owner  = -1;
    end else begin
      m_write = acc;
      if (acc) m_din = req_data[win*DW +: DW];
      if (rd && m_credit == DP) m_err = 1'b1;
      m_credit = m_credit - (acc ? 1 : 0) + ((rd && m_credit != DP) ? 1 : 0);
      if (acc) begin
        m_ptr = win;
`ifdef FIFO_ARB_LOCK_EN
        if (lk[win]) m_owner = win;
`endif
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [NR-1:0] exp_g;
    req_data = {16'h3333, 16'h2222, 16'h1111, 16'hA5A5};

    // 1: single producer, one-cycle write latency
    step('0, '0, 1'b0, 1'b1);
    chk("rst_credit", {27'd0, credit_cnt}, 32'd16);
    chk("rst_write", {31'd0, fifo_write}, 32'd0);
    chk("rst_err", {31'd0, err_undf}, 32'd0);
    step(4'b0001, '0, 1'b0, 1'b0);
    chk("t1_gnt", {28'd0, obs_gnt}, 32'd1);
    chk("t1_write", {31'd0, fifo_write}, 32'd1);
    chk("t1_din", {16'd0, fifo_din}, 32'hA5A5);
    chk("t1_credit", {27'd0, credit_cnt}, 32'd15);

    // 2: all requesting, rotating grants
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, '0, 1'b0, 1'b0);
      exp_g = '0;
      exp_g[i % NR] = 1'b1;
      chk("t2_order", {28'd0, obs_gnt}, {28'd0, exp_g});
    end
    chk("t2_credit", {27'd0, credit_cnt}, 32'd8);

    // 3: fill to empty credits, stall, single read unblocks one word
    for (int i = 0; i < 8; i++) step(4'b1111, '0, 1'b0, 1'b0);
    chk("t3_credit0", {27'd0, credit_cnt}, 32'd0);
    step(4'b1111, '0, 1'b0, 1'b0);
    chk("t3_stall_gnt", {28'd0, obs_gnt}, 32'd0);
    step(4'b1111, '0, 1'b1, 1'b0);
    chk("t3_rd_gnt", {28'd0, obs_gnt}, 32'd1);
    chk("t3_rd_credit", {27'd0, credit_cnt}, 32'd0);
    step('0, '0, 1'b0, 1'b0);

    // 4: read with a full credit count is an underflow, sticky until reset
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b1, 1'b0);
    chk("t4_credit", {27'd0, credit_cnt}, 32'd16);
    chk("t4_err", {31'd0, err_undf}, 32'd1);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b0);
    chk("t4_sticky", {31'd0, err_undf}, 32'd1);
    step('0, '0, 1'b0, 1'b1);
    chk("t4_cleared", {31'd0, err_undf}, 32'd0);

    // 5: reset right after an accept drops the pending write
    step(4'b0010, '0, 1'b0, 1'b0);
    step(4'b0010, '0, 1'b0, 1'b1);
    chk("t5_rst_gnt", {28'd0, obs_gnt}, 32'd0);
    chk("t5_write", {31'd0, fifo_write}, 32'd0);
    chk("t5_credit", {27'd0, credit_cnt}, 32'd16);
    step(4'b1111, '0, 1'b0, 1'b0);
    chk("t5_first", {28'd0, obs_gnt}, 32'd1);

`ifdef FIFO_ARB_LOCK_EN
    // 6: burst hold on requester 1, then release rotates to requester 2
    step('0, '0, 1'b0, 1'b1);
    step(4'b0001, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0010, 1'b0, 1'b0);
      chk("t6_lock", {28'd0, obs_gnt}, 32'd2);
    end
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("t6_release", {28'd0, obs_gnt}, 32'd4);
`endif

    // 7: random traffic, first read-starved then read-heavy
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 700; i++) begin
      req_data = {$urandom, $urandom};
      step(NR'($urandom), NR'($urandom),
           (i < 350) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
